hazard_unit: RTL and testbench
==============================

# hazard_unit

Parametrised hazard and forwarding controller for the Riscv151 pipeline, sitting beside `control` in the decode stage. It tracks every in-flight instruction downstream of decode in a shift-register scoreboard and selects a forwarding source per operand. It stalls decode on load-use hazards and squashes wrong-path instructions after a redirect. Pipeline depth, load latency and flush length are parameters, so the same block serves the 3-stage core and deeper variants.

## Interface
Parameters:
- `ADDR_W`, 5, register-address width.
- `DEPTH`, 2, number of tracked stages after decode. Stage 1 = X, stage `DEPTH` = the stage currently writing the register file.
- `LOAD_LAT`, 1, number of stages past decode before load data exists. A load in stage k is forwardable only when k > `LOAD_LAT`. Legal range 0..`DEPTH`-1.
- `KILL_CYCLES`, 1, number of decode cycles squashed per redirect. Must be ≥1.
- Derived: `SEL_W` = $clog2(`DEPTH`+1).

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `id_valid` in 1: decode holds a real instruction.
- `id_rs1`, `id_rs2` in `ADDR_W`: decode source registers.
- `id_rs1_used`, `id_rs2_used` in 1: the operand is actually read.
- `id_rd` in `ADDR_W`: decode destination register.
- `id_we` in 1: decode instruction writes `id_rd`.
- `id_is_load` in 1: decode instruction is a load.
- `redirect` in 1: branch taken or jump resolved in X this cycle.
- `stall` out 1: hold PC and decode; a bubble enters X.
- `kill` out 1: the decode instruction is squashed; a bubble enters X.
- `fwd_a`, `fwd_b` out `SEL_W`: 0 = register file; k = result currently in stage k.
- `inflight` out `SEL_W`: count of valid writing entries, registered.

## Operation
- The scoreboard holds `DEPTH` entries of {valid, rd, load}. Each cycle every entry shifts k→k+1, and entry `DEPTH` drops out.
- Entry 1 loads {1, `id_rd`, `id_is_load`} when `id_valid` & `id_we` & `id_rd`≠0 & !`stall` & !`kill`. Otherwise entry 1 loads a bubble (valid=0).
- Operand match rule: an operand matches entry k if the operand is used, its register ≠0, entry k is valid, and entry k's rd = operand.
- Priority: the lowest matching k wins, so the youngest producer is chosen. `fwd_x` = that k, or 0 if nothing matches.
- Load-use: if the winning entry for either operand is a load with k ≤ `LOAD_LAT`, then `stall` = 1 and both `fwd` outputs are 0.
- Non-load producers are always forwardable from stage 1.
- Kill counter:
  - `redirect` loads the counter with `KILL_CYCLES`-1.
  - `kill` = `redirect` | (counter≠0). The counter decrements while nonzero.
  - A `redirect` arriving while the counter is nonzero reloads it.
- Simultaneous events:
  - `redirect` and a load-use condition in the same cycle: kill wins, so `stall` = 0 and a bubble is inserted.
  - `id_valid` = 0: `stall` = 0, and `fwd` outputs are don't-care but driven 0.
- `inflight` is the popcount of valid entries after the update.
- Mid-operation reset: all entries are invalidated and the counter is cleared on that edge, with no partial flush.

## Timing
- `fwd_a`, `fwd_b`, `stall` and `kill` are combinational from the registered scoreboard and counter plus the current id_* inputs and `redirect`. They are valid in the same cycle and are registered by the datapath into X.
- A stalled instruction re-evaluates the next cycle against the shifted scoreboard. The stall length is `LOAD_LAT`-k+1 cycles for a load at stage k.
- `kill` spans exactly `KILL_CYCLES` consecutive cycles starting in the `redirect` cycle.
- Reset values:
  - all entries invalid and counter = 0;
  - `stall` = 0, `fwd_a` = `fwd_b` = 0, `inflight` = 0;
  - `kill` follows `redirect` combinationally.

## Test plan
All scenarios use `DEPTH`=3, `LOAD_LAT`=1, `KILL_CYCLES`=2.
- Reset: assert `reset` with stimulus active → next cycle `inflight`=0; `stall`, `fwd_a`, `fwd_b` = 0; `kill`=0 once `redirect` is low.
- ALU chain: `add x5` then `add x6,x5,x5` in consecutive cycles → `fwd_a`=`fwd_b`=1. A third instruction reading x5 → `fwd_a`=2. The fourth such reader → `fwd_a`=3. The fifth reader → `fwd_a`=0.
- Load-use: `lw x7` then `add x8,x7,x0` → `stall`=1 for exactly 1 cycle and `inflight` rises by 1 only. The following cycle has `stall`=0 and `fwd_a`=2, `fwd_b`=0.
- Priority / x0: x5 written by instructions now in stages 1 and 2, consumer reads x5 → `fwd_a`=1. A consumer reading x0 after `addi x0` → `fwd_a`=0. An operand with `id_rs2_used`=0 that matches → `fwd_b`=0.
- Redirect during load-use: `redirect`=1 in the same cycle a load-use stall would fire → `stall`=0 and `kill`=1 for 2 cycles, no entries inserted, `inflight` decays to 0.
- Back-to-back redirects: a second `redirect` in the kill tail → `kill` extends to 2 cycles from the second redirect.

Source files
------------

// File: rtl/hazard_unit.sv
// Decode-stage hazard and forwarding controller: shift-register scoreboard of
// in-flight writers, per-operand forward select, load-use stall and redirect kill.
module hazard_unit #(
   parameter int unsigned ADDR_W      = 5,
   parameter int unsigned DEPTH       = 2,
   parameter int unsigned LOAD_LAT    = 1,
   parameter int unsigned KILL_CYCLES = 1,
   localparam int unsigned SEL_W      = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [ADDR_W-1:0] id_rs1,
   input  logic [ADDR_W-1:0] id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [ADDR_W-1:0] id_rd,
   input  logic              id_we,
   input  logic              id_is_load,
   input  logic              redirect,
   output logic              stall,
   output logic              kill,
   output logic [SEL_W-1:0]  fwd_a,
   output logic [SEL_W-1:0]  fwd_b,
   output logic [SEL_W-1:0]  inflight
);

   localparam int unsigned CNT_W = (KILL_CYCLES > 1) ? $clog2(KILL_CYCLES) : 1;

   // Entry index i holds pipeline stage i+1
   logic [DEPTH-1:0]  sb_valid, sb_valid_nxt;
   logic [DEPTH-1:0]  sb_load, sb_load_nxt;
   logic [ADDR_W-1:0] sb_rd [DEPTH];
   logic [ADDR_W-1:0] sb_rd_nxt [DEPTH];
   logic [CNT_W-1:0]  kill_cnt, kill_cnt_nxt;
   logic [SEL_W-1:0]  inflight_nxt;

   logic              hit_a, hit_b, load_a, load_b;
   logic [SEL_W-1:0]  idx_a, idx_b;
   logic              load_use, insert;

   // Youngest matching producer per operand: scan oldest first, younger overwrites
   always_comb begin
      hit_a  = 1'b0;
      hit_b  = 1'b0;
      load_a = 1'b0;
      load_b = 1'b0;
      idx_a  = '0;
      idx_b  = '0;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         if (id_rs1_used && (id_rs1 != '0) && sb_valid[i] && (sb_rd[i] == id_rs1)) begin
            hit_a  = 1'b1;
            idx_a  = SEL_W'(i + 1);
            load_a = sb_load[i];
         end
         if (id_rs2_used && (id_rs2 != '0) && sb_valid[i] && (sb_rd[i] == id_rs2)) begin
            hit_b  = 1'b1;
            idx_b  = SEL_W'(i + 1);
            load_b = sb_load[i];
         end
      end
   end

   // Stall/kill/forward decisions; kill overrides a load-use stall
   always_comb begin
      load_use = id_valid &&
                 ((hit_a && load_a && (idx_a <= SEL_W'(LOAD_LAT))) ||
                  (hit_b && load_b && (idx_b <= SEL_W'(LOAD_LAT))));
      kill     = redirect || (kill_cnt != '0);
      stall    = load_use && !kill;
      fwd_a    = (id_valid && !load_use) ? idx_a : '0;
      fwd_b    = (id_valid && !load_use) ? idx_b : '0;
      insert   = id_valid && id_we && (id_rd != '0) && !stall && !kill;
   end

   // Scoreboard shift, occupancy and kill countdown
   always_comb begin
      sb_valid_nxt    = '0;
      sb_load_nxt     = '0;
      sb_rd_nxt[0]    = id_rd;
      sb_valid_nxt[0] = insert;
      sb_load_nxt[0]  = insert && id_is_load;
      for (int i = 1; i < int'(DEPTH); i++) begin
         sb_valid_nxt[i] = sb_valid[i-1];
         sb_load_nxt[i]  = sb_load[i-1];
         sb_rd_nxt[i]    = sb_rd[i-1];
      end
      inflight_nxt = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         inflight_nxt = inflight_nxt + SEL_W'(sb_valid_nxt[i]);
      end
      kill_cnt_nxt = kill_cnt;
      if (redirect) begin
         kill_cnt_nxt = CNT_W'(KILL_CYCLES - 1);
      end else if (kill_cnt != '0) begin
         kill_cnt_nxt = kill_cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sb_valid <= '0;
         sb_load  <= '0;
         kill_cnt <= '0;
         inflight <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            sb_rd[i] <= '0;
         end
      end else begin
         sb_valid <= sb_valid_nxt;
         sb_load  <= sb_load_nxt;
         kill_cnt <= kill_cnt_nxt;
         inflight <= inflight_nxt;
         for (int i = 0; i < int'(DEPTH); i++) begin
            sb_rd[i] <= sb_rd_nxt[i];
         end
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit with DEPTH=3, LOAD_LAT=1, KILL_CYCLES=2.
module tb_hazard_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid, id_rs1_used, id_rs2_used, id_we, id_is_load, redirect;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic       stall, kill;
   logic [1:0] fwd_a, fwd_b, inflight;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   hazard_unit #(
      .ADDR_W(5), .DEPTH(3), .LOAD_LAT(1), .KILL_CYCLES(2)
   ) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
      .redirect(redirect), .stall(stall), .kill(kill),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .inflight(inflight)
   );

   // Advance one edge; inputs change and outputs settle 1ns after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic we, input logic ld);
      id_valid = v;   id_rs1 = rs1; id_rs1_used = u1;
      id_rs2 = rs2;   id_rs2_used = u2;
      id_rd = rd;     id_we = we;   id_is_load = ld;
      #1;
   endtask

   task automatic drain();
      redirect = 1'b0;
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      repeat (4) step();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      redirect = 1'b1;
      drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1);
      step();
      step();
      n_checks++;
      if (inflight !== 2'd0) $display("FAIL reset_inflight got %0d exp 0", inflight); else n_pass++;
      n_checks++;
      if (kill !== 1'b1) $display("FAIL reset_kill_follows_redirect got %0b exp 1", kill); else n_pass++;
      redirect = 1'b0;
      #1;
      n_checks++;
      if (kill !== 1'b0) $display("FAIL reset_kill got %0b exp 0", kill); else n_pass++;
      n_checks++;
      if (stall !== 1'b0 || fwd_a !== 2'd0 || fwd_b !== 2'd0)
         $display("FAIL reset_outputs got stall=%0b fwd_a=%0d fwd_b=%0d exp 0/0/0", stall, fwd_a, fwd_b);
      else n_pass++;
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      step();
      reset = 1'b0;
   endtask

   task automatic test_alu_chain();
      drain();
      drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);   // add x5,x1,x2
      step();
      n_checks++;
      if (inflight !== 2'd1) $display("FAIL alu_inflight1 got %0d exp 1", inflight); else n_pass++;
      drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);   // add x6,x5,x5
      n_checks++;
      if (fwd_a !== 2'd1 || fwd_b !== 2'd1 || stall !== 1'b0)
         $display("FAIL alu_fwd_stage1 got fwd_a=%0d fwd_b=%0d stall=%0b exp 1/1/0", fwd_a, fwd_b, stall);
      else n_pass++;
      step();
      drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0);   // add x9,x5,x0
      n_checks++;
      if (fwd_a !== 2'd2 || fwd_b !== 2'd0) $display("FAIL alu_fwd_stage2 got fwd_a=%0d fwd_b=%0d exp 2/0", fwd_a, fwd_b); else n_pass++;
      step();
      n_checks++;
      if (inflight !== 2'd3) $display("FAIL alu_inflight3 got %0d exp 3", inflight); else n_pass++;
      drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd10, 1'b1, 1'b0);  // add x10,x5,x0
      n_checks++;
      if (fwd_a !== 2'd3) $display("FAIL alu_fwd_stage3 got %0d exp 3", fwd_a); else n_pass++;
      step();
      drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd11, 1'b1, 1'b0);  // add x11,x5,x0
      n_checks++;
      if (fwd_a !== 2'd0) $display("FAIL alu_fwd_retired got %0d exp 0", fwd_a); else n_pass++;
      step();
   endtask

   task automatic test_load_use();
      drain();
      n_checks++;
      if (inflight !== 2'd0) $display("FAIL lu_drained got %0d exp 0", inflight); else n_pass++;
      drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);   // lw x7,0(x2)
      step();
      n_checks++;
      if (inflight !== 2'd1) $display("FAIL lu_inflight_load got %0d exp 1", inflight); else n_pass++;
      drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);   // add x8,x7,x0
      n_checks++;
      if (stall !== 1'b1 || fwd_a !== 2'd0 || fwd_b !== 2'd0)
         $display("FAIL lu_stall got stall=%0b fwd_a=%0d fwd_b=%0d exp 1/0/0", stall, fwd_a, fwd_b);
      else n_pass++;
      step();
      n_checks++;
      if (inflight !== 2'd1) $display("FAIL lu_bubble_inflight got %0d exp 1", inflight); else n_pass++;
      n_checks++;
      if (stall !== 1'b0 || fwd_a !== 2'd2 || fwd_b !== 2'd0)
         $display("FAIL lu_release got stall=%0b fwd_a=%0d fwd_b=%0d exp 0/2/0", stall, fwd_a, fwd_b);
      else n_pass++;
      step();
      n_checks++;
      if (inflight !== 2'd2) $display("FAIL lu_inflight_after got %0d exp 2", inflight); else n_pass++;
   endtask

   task automatic test_priority_x0();
      drain();
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);   // first x5 writer
      step();
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);   // second x5 writer
      step();
      drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 1'b0);   // addi x0,x5 with rs2 unused
      n_checks++;
      if (fwd_a !== 2'd1) $display("FAIL prio_youngest got %0d exp 1", fwd_a); else n_pass++;
      n_checks++;
      if (fwd_b !== 2'd0) $display("FAIL prio_rs2_unused got %0d exp 0", fwd_b); else n_pass++;
      step();
      n_checks++;
      if (inflight !== 2'd2) $display("FAIL prio_x0_not_tracked got %0d exp 2", inflight); else n_pass++;
      drive(1'b1, 5'd0, 1'b1, 5'd5, 1'b1, 5'd12, 1'b1, 1'b0);  // reads x0 and x5
      n_checks++;
      if (fwd_a !== 2'd0) $display("FAIL prio_x0_read got %0d exp 0", fwd_a); else n_pass++;
      n_checks++;
      if (fwd_b !== 2'd2) $display("FAIL prio_after_bubble got %0d exp 2", fwd_b); else n_pass++;
      step();
   endtask

   task automatic test_redirect_load_use();
      drain();
      drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);   // lw x7
      step();
      redirect = 1'b1;
      drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);   // add x8,x7
      n_checks++;
      if (stall !== 1'b0 || kill !== 1'b1)
         $display("FAIL rdlu_first got stall=%0b kill=%0b exp 0/1", stall, kill);
      else n_pass++;
      step();
      redirect = 1'b0;
      #1;
      n_checks++;
      if (inflight !== 2'd1) $display("FAIL rdlu_no_insert got %0d exp 1", inflight); else n_pass++;
      n_checks++;
      if (stall !== 1'b0 || kill !== 1'b1)
         $display("FAIL rdlu_second got stall=%0b kill=%0b exp 0/1", stall, kill);
      else n_pass++;
      step();
      n_checks++;
      if (inflight !== 2'd1) $display("FAIL rdlu_no_insert2 got %0d exp 1", inflight); else n_pass++;
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      n_checks++;
      if (kill !== 1'b0) $display("FAIL rdlu_kill_end got %0b exp 0", kill); else n_pass++;
      step();
      n_checks++;
      if (inflight !== 2'd0) $display("FAIL rdlu_decay got %0d exp 0", inflight); else n_pass++;
   endtask

   task automatic test_back_to_back();
      drain();
      redirect = 1'b1;
      #1;
      n_checks++;
      if (kill !== 1'b1) $display("FAIL b2b_kill0 got %0b exp 1", kill); else n_pass++;
      step();
      n_checks++;
      if (kill !== 1'b1) $display("FAIL b2b_kill1 got %0b exp 1", kill); else n_pass++;
      step();
      redirect = 1'b0;
      #1;
      n_checks++;
      if (kill !== 1'b1) $display("FAIL b2b_kill_ext got %0b exp 1", kill); else n_pass++;
      step();
      n_checks++;
      if (kill !== 1'b0) $display("FAIL b2b_kill_end got %0b exp 0", kill); else n_pass++;
   endtask

   task automatic test_mid_reset();
      redirect = 1'b1;
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
      step();
      redirect = 1'b0;
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      n_checks++;
      if (kill !== 1'b0 || inflight !== 2'd0)
         $display("FAIL midreset got kill=%0b inflight=%0d exp 0/0", kill, inflight);
      else n_pass++;
   endtask

   initial begin
      reset = 1'b1;
      redirect = 1'b0;
      id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0;
      id_rs2_used = 1'b0; id_rd = '0; id_we = 1'b0; id_is_load = 1'b0;
      test_reset();
      test_alu_chain();
      test_load_use();
      test_priority_x0();
      test_redirect_load_use();
      test_back_to_back();
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
